vixen_imem_responder: RTL and testbench

Instruction-memory responder serving the frontend fetch port. It accepts a line-address fetch request from the fetch stage and fills one 512-bit instruction line from a narrow backing-memory bus in BEATS sequential beats. It returns the line with a single-cycle `imem_ready` pulse. It sits between the frontend fetch pipeline and the external instruction memory, and bounds fill time with a watchdog.

---
 rtl/vixen_imem_responder_if.sv | 23 ++
 rtl/vixen_imem_responder.sv | 92 +++++++++
 tb/tb_vixen_imem_responder.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/vixen_imem_responder_if.sv
// vixen_imem_responder_if: fetch-port and backing-memory signals of the instruction-memory responder.
interface vixen_imem_responder_if #(
   parameter int BEAT_W = 64
);
   logic              imem_req;
   logic [63:0]       imem_addr;
   logic [511:0]      imem_data;
   logic              imem_ready;
   logic              imem_err;
   logic              mem_req;
   logic [63:0]       mem_addr;
   logic              mem_gnt;
   logic              mem_rvalid;
   logic [BEAT_W-1:0] mem_rdata;
   modport slave (
      input  imem_req, imem_addr, mem_gnt, mem_rvalid, mem_rdata,
      output imem_data, imem_ready, imem_err, mem_req, mem_addr
   );
   modport master (
      output imem_req, imem_addr, mem_gnt, mem_rvalid, mem_rdata,
      input  imem_data, imem_ready, imem_err, mem_req, mem_addr
   );
endinterface

// File: rtl/vixen_imem_responder.sv
// vixen_imem_responder: fills one 512-bit instruction line from a BEAT_W-wide memory bus, with a fill watchdog.
// Define VIXEN_IMEM_LINEBUF_EN for a one-entry line buffer that answers repeat fetches in one cycle.
module vixen_imem_responder #(
   parameter int BEAT_W         = 64,
   parameter int TIMEOUT_CYCLES = 256
) (
   input logic                   clk,
   input logic                   rst_n,
   vixen_imem_responder_if.slave io_bus
);
   localparam int BEATS = 512 / BEAT_W;
   localparam int BCW   = BEATS > 1 ? $clog2(BEATS) : 1;
   localparam int WDW   = $clog2(TIMEOUT_CYCLES + 1);
   typedef enum logic [1:0] {IDLE, REQ, FILL, RESP} state_t;
   state_t         r_state, w_state_n;
   logic [BCW-1:0] r_beat;
   logic [WDW-1:0] r_wd;
   logic [511:0]   r_data;
   logic [63:0]    r_mem_addr;
   logic           r_ready, r_err, r_mem_req;
   logic           w_hit, w_gnt, w_beat, w_last, w_timeout, w_wd_run;
`ifdef VIXEN_IMEM_LINEBUF_EN
   logic [57:0] r_tag;
   logic        r_tag_vld;
   assign w_hit = r_tag_vld && r_tag == io_bus.imem_addr[63:6];
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_tag     <= '0;
         r_tag_vld <= 1'b0;
      end else if (w_timeout) begin
         r_tag_vld <= 1'b0;
      end else if (w_last) begin
         r_tag     <= r_mem_addr[63:6];
         r_tag_vld <= 1'b1;
      end
`else
   assign w_hit = 1'b0;
`endif
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_state <= IDLE;
      else r_state <= w_state_n;
   always_comb begin
      w_state_n = r_state;
      w_gnt     = 1'b0;
      w_beat    = 1'b0;
      w_last    = 1'b0;
      w_timeout = 1'b0;
      case (r_state)
         IDLE: w_state_n = io_bus.imem_req ? (w_hit ? RESP : REQ) : IDLE;
         REQ: begin
            w_gnt     = io_bus.mem_gnt;
            w_timeout = !io_bus.mem_gnt && r_wd == WDW'(TIMEOUT_CYCLES);
            w_state_n = w_gnt ? FILL : w_timeout ? RESP : REQ;
         end
         FILL: begin
            w_beat    = io_bus.mem_rvalid;
            w_last    = io_bus.mem_rvalid && r_beat == BCW'(BEATS - 1);
            w_timeout = !io_bus.mem_rvalid && r_wd == WDW'(TIMEOUT_CYCLES);
            w_state_n = (w_last || w_timeout) ? RESP : FILL;
         end
         RESP: w_state_n = IDLE;
      endcase
   end
   assign w_wd_run = r_state == REQ || r_state == FILL;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_beat     <= '0;
         r_wd       <= '0;
         r_data     <= '0;
         r_mem_addr <= '0;
         r_mem_req  <= 1'b0;
         r_ready    <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_ready <= w_state_n == RESP && io_bus.imem_req;
         r_err   <= w_timeout && io_bus.imem_req;
         r_wd    <= (!w_wd_run || w_gnt || w_beat || w_timeout) ? '0 : r_wd + 1'b1;
         if (r_state == IDLE && io_bus.imem_req) r_mem_addr <= io_bus.imem_addr & ~64'h3f;
         if (r_state == IDLE && io_bus.imem_req && !w_hit) r_mem_req <= 1'b1;
         else if (w_gnt || w_timeout) r_mem_req <= 1'b0;
         // the counter holds on the last beat so it never wraps inside a fill
         if (w_gnt) r_beat <= '0;
         else if (w_beat && !w_last) r_beat <= r_beat + 1'b1;
         if (w_timeout) r_data <= '0;
         else if (w_beat) r_data[int'(r_beat) * BEAT_W +: BEAT_W] <= io_bus.mem_rdata;
      end
   assign io_bus.imem_data  = r_data;
   assign io_bus.imem_ready = r_ready;
   assign io_bus.imem_err   = r_err;
   assign io_bus.mem_req    = r_mem_req;
   assign io_bus.mem_addr   = r_mem_addr;
endmodule

// File: tb/tb_vixen_imem_responder.sv
// tb_vixen_imem_responder: directed fetch scenarios checked every cycle against a transaction-level model.
module tb_vixen_imem_responder;
`ifdef VIXEN_IMEM_LINEBUF_EN
   localparam bit LB = 1'b1;
`else
   localparam bit LB = 1'b0;
`endif
   localparam int TO = 256;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int n_tests = 0, n_fail = 0, cyc = 0;
   int ready_cnt = 0, ready_edge = 0, last_beat_edge = 0;
   logic [511:0] rdy_data;
   logic rdy_err;
   logic [63:0] seen_addr;
   logic exp_ready = 0, exp_err = 0, exp_mem_req = 0;
   logic [511:0] exp_data = '0;
   logic [63:0] exp_mem_addr = '0;
   bit m_pend, m_gnt, m_resp, m_bv;
   int m_nb, m_quiet;
   logic [57:0] m_btag;
   vixen_imem_responder_if #(.BEAT_W(64)) bus ();
   vixen_imem_responder #(.BEAT_W(64), .TIMEOUT_CYCLES(TO)) dut (.clk(clk), .rst_n(rst_n), .io_bus(bus));
   initial forever #5 clk = ~clk;
   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic tick();
      @(negedge clk);
   endtask
   // Line-level model: a request is pending until granted, then collects 8 beats or times out.
   initial forever begin
      bit nr, ne, tmo;
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         m_pend = 0; m_gnt = 0; m_resp = 0; m_bv = 0; m_nb = 0; m_quiet = 0; m_btag = '0;
         exp_ready = 0; exp_err = 0; exp_mem_req = 0; exp_data = '0; exp_mem_addr = '0;
      end else begin
         nr = 0; ne = 0; tmo = 0;
         if (m_resp) m_resp = 0;
         else if (!m_pend) begin
            if (bus.imem_req) begin
               exp_mem_addr = bus.imem_addr & ~64'h3f;
               if (LB && m_bv && m_btag == bus.imem_addr[63:6]) begin m_resp = 1; nr = 1; end
               else begin m_pend = 1; m_gnt = 0; m_quiet = 0; exp_mem_req = 1; end
            end
         end else if (!m_gnt) begin
            if (bus.mem_gnt) begin m_gnt = 1; m_nb = 0; m_quiet = 0; exp_mem_req = 0; end
            else if (m_quiet == TO) tmo = 1;
            else m_quiet++;
         end else if (bus.mem_rvalid) begin
            exp_data[m_nb*64 +: 64] = bus.mem_rdata;
            m_nb++;
            m_quiet = 0;
            if (m_nb == 8) begin
               m_pend = 0; m_resp = 1; nr = bus.imem_req; m_bv = 1; m_btag = exp_mem_addr[63:6];
            end
         end else if (m_quiet == TO) tmo = 1;
         else m_quiet++;
         if (tmo) begin
            m_pend = 0; m_resp = 1; nr = bus.imem_req; ne = bus.imem_req;
            exp_data = '0; m_bv = 0; exp_mem_req = 0;
         end
         exp_ready = nr;
         exp_err = ne;
      end
   end
   initial forever begin
      @(posedge clk);
      cyc++;
      #1;
      chk("cyc_ready", bus.imem_ready, exp_ready);
      chk("cyc_err", bus.imem_err, exp_err);
      chk("cyc_mem_req", bus.mem_req, exp_mem_req);
      chk("cyc_mem_addr", bus.mem_addr, exp_mem_addr);
      chk("cyc_data", bus.imem_data, exp_data);
      if (bus.imem_ready) begin
         ready_cnt++;
         ready_edge = cyc;
         rdy_data = bus.imem_data;
         rdy_err = bus.imem_err;
      end
   end
   task automatic serve(input int gd, input int ga, input int gl, input int nb, input int drop, input logic [63:0] base);
      int w = 0;
      tick();
      while (!bus.mem_req && w < 20) begin tick(); w++; end
      chk("mem_req_seen", bus.mem_req, 1);
      seen_addr = bus.mem_addr;
      repeat (gd) tick();
      bus.mem_gnt = 1;
      tick();
      bus.mem_gnt = 0;
      for (int k = 0; k < nb; k++) begin
         if (k == drop) bus.imem_req = 0;
         bus.mem_rvalid = 1;
         bus.mem_rdata = base + 64'(k);
         tick();
         bus.mem_rvalid = 0;
         last_beat_edge = cyc;
         if (k == ga) repeat (gl) tick();
      end
   endtask
   task automatic fetch(input logic [63:0] a, input int gd, input int ga, input int gl, input logic [63:0] base, input int lat);
      int n0 = ready_cnt;
      int s = cyc + 1;
      bus.imem_req = 1;
      bus.imem_addr = a;
      serve(gd, ga, gl, 8, -1, base);
      chk("ready_count", ready_cnt - n0, 1);
      chk("ready_after_last_beat", ready_edge, last_beat_edge);
      chk("latency", ready_edge - s, lat);
      chk("mem_addr_line", seen_addr, a & ~64'h3f);
      chk("line_lo", rdy_data[63:0], base);
      chk("line_hi", rdy_data[511:448], base + 64'd7);
      chk("err_clear", rdy_err, 0);
      bus.imem_req = 0;
      tick();
   endtask
   initial begin
      int n0, s;
      bus.imem_req = 0; bus.imem_addr = '0; bus.mem_gnt = 0; bus.mem_rvalid = 0; bus.mem_rdata = '0;
      repeat (3) tick();
      chk("rst_ready", bus.imem_ready, 0);
      chk("rst_data", bus.imem_data, 0);
      chk("rst_mem_req", bus.mem_req, 0);
      rst_n = 1;
      tick();
      fetch(64'h1000_0004, 0, 9, 0, 64'h1111_2222_3333_4400, 9);
      chk("mem_addr_lit", seen_addr, 64'h1000_0000);
      fetch(64'h1000_0180, 5, 3, 3, 64'hA5A5_0000_0000_0000, 17);
      n0 = ready_cnt; s = cyc + 1;
      bus.imem_req = 1; bus.imem_addr = 64'h2000_0000;
      for (int w = 0; w < 400 && ready_cnt == n0; w++) tick();
      chk("to_ready", ready_cnt - n0, 1);
      chk("to_latency", ready_edge - s, 257);
      chk("to_err", rdy_err, 1);
      chk("to_data", rdy_data, 0);
      bus.imem_req = 0;
      bus.mem_rvalid = 1; bus.mem_rdata = 64'hDEAD_BEEF;
      repeat (3) tick();
      bus.mem_rvalid = 0;
      tick();
      chk("stray_data", bus.imem_data, 0);
      bus.imem_req = 1; bus.imem_addr = 64'h4000_0000;
      serve(0, 9, 0, 4, -1, 64'h4444_0000_0000_0000);
      rst_n = 0; bus.imem_req = 0;
      tick();
      chk("mid_rst_data", bus.imem_data, 0);
      chk("mid_rst_mem_addr", bus.mem_addr, 0);
      chk("mid_rst_ready", bus.imem_ready, 0);
      chk("mid_rst_err", bus.imem_err, 0);
      rst_n = 1;
      bus.mem_rvalid = 1; bus.mem_rdata = 64'h5555;
      repeat (4) tick();
      bus.mem_rvalid = 0;
      chk("late_beats_data", bus.imem_data, 0);
      chk("late_beats_mem_req", bus.mem_req, 0);
      fetch(64'h4000_0000, 0, 9, 0, 64'h4444_0000_0000_0100, 9);
      n0 = ready_cnt;
      bus.imem_req = 1; bus.imem_addr = 64'h3000_0000;
      serve(1, 9, 0, 8, 2, 64'h3333_0000_0000_0000);
      repeat (2) tick();
      chk("drop_no_ready", ready_cnt - n0, 0);
      chk("drop_kept_line", bus.imem_data[511:448], 64'h3333_0000_0000_0007);
      chk("drop_mem_req", bus.mem_req, 0);
      fetch(64'h1000_0000, 0, 9, 0, 64'h6666_0000_0000_0000, 9);
`ifdef VIXEN_IMEM_LINEBUF_EN
      n0 = ready_cnt; s = cyc + 1;
      bus.imem_req = 1; bus.imem_addr = 64'h1000_0020;
      tick();
      chk("hit_ready", ready_cnt - n0, 1);
      chk("hit_latency", ready_edge - s, 0);
      chk("hit_line", rdy_data[63:0], 64'h6666_0000_0000_0000);
      chk("hit_mem_req", bus.mem_req, 0);
      repeat (2) tick();
      chk("b2b_ready", ready_cnt - n0, 2);
      chk("b2b_spacing", ready_edge - s, 2);
      bus.imem_req = 0;
      tick();
`else
      fetch(64'h1000_0020, 0, 9, 0, 64'h7777_0000_0000_0000, 9);
`endif
      fetch(64'h1000_0040, 2, 9, 0, 64'h8888_0000_0000_0000, 11);
      repeat (2) tick();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
   initial begin
      #60000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end
endmodule
